// File: rtl/regwrite_trace_fifo.sv
// Register write-back trace FIFO: logs every traced register write
// (pc, rd, data, seq) and drains it through a valid/ready port.
//
// Ports:
//   clk, reset       clock, async active-high reset
//   trace_en, clr    capture enable, sync flush
//   wb_en/addr/data/pc
//                    register-file write-back tap
//   tr_valid/ready   show-ahead output handshake
//   tr_pc/addr/data/seq
//                    head entry fields
//   count            occupancy 0..DEPTH
//   overflow         sticky drop flag
//   drop_cnt         saturating drop count
module regwrite_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trace_en,
  input  logic              clr,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [31:0]       wb_data,
  input  logic [31:0]       wb_pc,
  output logic              tr_valid,
  input  logic              tr_ready,
  output logic [31:0]       tr_pc,
  output logic [4:0]        tr_addr,
  output logic [31:0]       tr_data,
  output logic [7:0]        tr_seq,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [7:0]  seq;
  } entry_t;

  entry_t              mem_q [DEPTH];
  entry_t              mem_d [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [7:0]          seq_q, seq_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;

  logic evt;
  logic pop;
  logic full;
  logic push;
  logic drop;

  entry_t head;

  assign head     = mem_q[rd_ptr_q];
  assign tr_valid = (count_q != '0);
  assign tr_pc    = head.pc;
  assign tr_addr  = head.addr;
  assign tr_data  = head.data;
  assign tr_seq   = head.seq;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

  always_comb begin
    evt  = wb_en & trace_en & (wb_addr != 5'd0);
    pop  = tr_valid & tr_ready;
    full = (count_q == FULL_CNT);
    // A pop in the same cycle frees the slot the push lands in.
    push = evt & (~full | pop);
    drop = evt & full & ~pop;
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    seq_d      = seq_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      seq_d      = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{
          pc:   wb_pc,
          addr: wb_addr,
          data: wb_data,
          seq:  seq_q
        };
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end

      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      // seq counts every qualifying event, so dropped
      // ones show up as gaps downstream.
      if (evt) begin
        seq_d = seq_q + 8'd1;
      end

      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: doc/regwrite_trace_fifo.md
Name: regwrite_trace_fifo

Overview:
- Sits directly downstream of the single-cycle datapath's register-file write-back port.
- Captures every architecturally visible register write (PC, destination register, data) into a show-ahead FIFO.
- Entries drain through a valid/ready handshake to a trace sink (bench monitor or debug UART).
- Replaces polling of fixed register taps with a complete, ordered write log, including drop accounting.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- trace_en  input  1  capture enable; 0 ignores write-back events.
- clr  input  1  synchronous flush of FIFO, counters and flags.
- wb_en  input  1  register-file write strobe from the datapath (RegWrite).
- wb_addr  input  5  destination register number.
- wb_data  input  32  data written.
- wb_pc  input  32  PC of the writing instruction.
- tr_valid  output  1  head entry available.
- tr_ready  input  1  sink accepts the head entry.
- tr_pc  output  32  head entry PC.
- tr_addr  output  5  head entry register number.
- tr_data  output  32  head entry data.
- tr_seq  output  8  head entry sequence number.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: at least one event dropped.
- drop_cnt  output  8  dropped events, saturating at 255.

Behaviour:
- Qualifying event (evt): wb_en=1, trace_en=1 and wb_addr!=0. Writes to $zero are never traced.
- Sequence counter seq (8 bits, internal):
  - Increments by 1 on every evt, accepted or dropped; wraps 255->0.
  - A stored entry carries the seq value before the increment.
  - Gaps in tr_seq therefore expose drops.
- Pop: tr_valid=1 and tr_ready=1 on a rising edge; head pointer advances.
- Push: evt=1 and (count<DEPTH, or a pop occurs in the same cycle). Entry is written at the tail pointer.
- Full with evt and no pop: event dropped, overflow set to 1, drop_cnt incremented unless already 255. FIFO contents unchanged.
- Push and pop in the same cycle: count unchanged. This applies when full (entry accepted) and when count=1. With count=0, no pop is possible and push only.
- Pointers: ADDR_W bits, wrap modulo DEPTH. count is held separately; full = (count==DEPTH), empty = (count==0).
- Read is show-ahead and registered-free:
  - tr_valid = (count!=0).
  - tr_pc/tr_addr/tr_data/tr_seq are driven combinationally from the head storage entry.
  - An entry pushed at edge N is visible at the output after edge N, so latency is 1 cycle from wb_en to tr_valid.
  - When tr_valid=0, tr_* fields are don't-care.
- tr_valid must not depend on tr_ready. The head entry stays stable while tr_valid=1 and tr_ready=0.
- clr=1 (synchronous) sets count=0, both pointers=0, seq=0, overflow=0, drop_cnt=0. It overrides push and pop in the same cycle.
- reset=1 (asynchronous, any time including mid-drain) forces:
  - count=0, pointers=0, seq=0, overflow=0, drop_cnt=0, tr_valid=0.
  - tr_pc/tr_addr/tr_data/tr_seq read 0; the storage array is cleared.
  - An event arriving on the release edge is captured normally.
- Outputs tr_pc/tr_addr/tr_data/tr_seq are 0 after reset until the first push.

Test Plan:
1. Reset, then 3 writes ($t0<-5 pc=0x00, $t1<-7 pc=0x04, $t2<-12 pc=0x08), tr_ready=1 -> three beats in order, tr_addr=8,9,10, tr_data=5,7,12, tr_seq=0,1,2, count returns to 0.
2. wb_en=1 with wb_addr=0, then trace_en=0 with a write to $s0 -> no entries, seq unchanged; next valid write carries tr_seq=0.
3. tr_ready=0, 18 qualifying writes (DEPTH=16) -> count=16, overflow=1, drop_cnt=2. Draining yields tr_seq 0..15; the next event gets seq 18.
4. Full FIFO, evt together with tr_ready=1 in the same cycle -> entry accepted, count stays 16, drop_cnt unchanged.
5. tr_ready toggling 1/0 every cycle while the head is held -> head fields are stable on every cycle with tr_ready=0, and no entry is duplicated or skipped.
6. Assert reset for 3 ns mid-drain with count=9 -> tr_valid=0 immediately (asynchronously), count=0; clr=1 with a simultaneous evt -> count=0, drop_cnt=0.
